fifo_read_arbiter: RTL and testbench
====================================

Name: fifo_read_arbiter

Overview:
Read-domain scheduler that shares the single async-FIFO read port (rempty/raddr/rdata, pop via rinc) among NUM_REQ consumers. Arbitration is round-robin, with a per-owner burst limit. Each popped word is held in an output register until the granted consumer accepts it. The block sits between read_empty plus the FIFO memory and the downstream consumers, in the rclk domain.

Parameters:
DATA_SIZE, 8, width of a FIFO word
NUM_REQ, 4, number of consumers (2..8)
BURST_MAX, 4, maximum consecutive words given to one owner while others request (≥1)

Ports:
rclk  in  1  read-domain clock
rrst  in  1  asynchronous, active-high reset
rempty  in  1  FIFO empty flag from read_empty
rdata  in  DATA_SIZE  FIFO read data at current raddr (combinational memory read)
rinc  out  1  FIFO pop strobe, one cycle wide
req  in  NUM_REQ  per-consumer request
gnt  out  NUM_REQ  one-hot current owner (all zero = none)
out_valid  out  1  out_data valid for gnt owner
out_data  out  DATA_SIZE  held word
out_ready  in  NUM_REQ  per-consumer accept
words_served  out  16  count of accepted words, wraps

Behaviour:
- Reset (rrst=1, async): state IDLE; rinc=0, gnt=0, out_valid=0, out_data=0, words_served=0, rr_ptr=0, burst_cnt=0. If reset hits during FETCH or HOLD, the word in flight is dropped; the FIFO is reset by the same system event.
- The FSM has states IDLE, FETCH and HOLD. All outputs are registered except rinc, which is asserted iff state==FETCH.
- IDLE:
  - If rempty=0 and req≠0, select an owner and go to FETCH. gnt updates on the same edge.
  - Otherwise stay in IDLE, gnt=0.
- Owner selection:
  - If the previous owner still has req asserted and burst_cnt<BURST_MAX, keep that owner.
  - Otherwise take the first asserted req scanning from rr_ptr upward with wrap. Set rr_ptr=winner+1 mod NUM_REQ and burst_cnt=0.
- FETCH (exactly 1 cycle): rinc=1, out_data<=rdata, out_valid<=1, go to HOLD.
- HOLD:
  - Hold out_valid and out_data stable until out_ready[owner]=1.
  - On accept: out_valid<=0, burst_cnt++ (saturating at BURST_MAX), words_served++ (16-bit wrap), go to IDLE.
  - out_ready of non-owners is ignored.
  - If req[owner] drops during HOLD, the word is still delivered; it is never discarded.
- Pop spacing:
  - rinc is never high on two consecutive cycles. The minimum pop interval is 3 cycles (FETCH→HOLD→IDLE→FETCH).
  - Reason: rempty from read_empty lags a pop by one cycle, so the value seen after the last word is popped is stale. The IDLE check always uses an rempty that already reflects the previous pop.
  - rempty cannot assert without a pop, so rempty=0 sampled in IDLE guarantees the FETCH pop is valid.
- Throughput: at most 1 word per 3 rclk cycles with out_ready held high. Added latency from IDLE decision to out_valid is 2 cycles.
- gnt stays one-hot through FETCH and HOLD. It changes only on the IDLE→FETCH transition or in IDLE, where it is cleared when nothing is requested or the FIFO is empty.
- Simultaneous events:
  - If accept and a req change happen in the same cycle, the new req is seen in the following IDLE.
  - If rempty deasserts in the same cycle a req arrives, the grant is issued on that edge.

Decomposition:
- fifo_pkg holds the state_t enum (IDLE, FETCH, HOLD) and the function computing index width $clog2(NUM_REQ).
- One sub-module, rr_picker: combinational round-robin first-one search from rr_ptr. Inputs are req and rr_ptr; outputs are winner index and a found flag.

Test Plan:
1. rrst=1 pulsed asynchronously mid-HOLD -> within the same cycle out_valid=0, gnt=0, rinc=0, words_served=0; the next pop occurs only after rempty=0 and req≠0.
2. rempty=1, req=4'b0001 for 10 cycles -> rinc=0, gnt=0 throughout. Then rempty=0, rdata=8'hA5 -> gnt=4'b0001 next edge, rinc=1 for exactly 1 cycle, then out_valid=1 with out_data=8'hA5.
3. BURST_MAX=2, req=4'b1111, 8 words preloaded, out_ready all 1 -> accepted owners in order 0,0,1,1,2,2,3,3; words_served=8.
4. out_ready[owner]=0 for 5 cycles in HOLD -> out_valid and out_data stable, rinc=0, gnt unchanged; accept on cycle 6 -> words_served+1.
5. FIFO holds 1 word, req held high -> exactly one rinc pulse, never two rinc on adjacent cycles; after rempty=1 the FSM stays in IDLE with gnt=0.
6. words_served preloaded near wrap (65535 accepts) -> the next accept shows 16'h0000.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
package fifo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_t;

  // Width of an index into NUM_REQ consumers; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted req at or above rr_ptr, with wrap.
module rr_picker
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [IDX_W-1:0] idx;

  // Scan NUM_REQ positions starting at rr_ptr; keep the first hit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares the async-FIFO read port among NUM_REQ consumers: round-robin with a
// per-owner burst limit, one popped word held until the owner accepts it.
module fifo_read_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rempty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  input  logic [NUM_REQ-1:0]   out_ready,
  output logic [15:0]          words_served
);

  localparam int unsigned IdxW  = idx_width(NUM_REQ);
  localparam int unsigned BcntW = $clog2(BURST_MAX + 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic                 own_vld_q, own_vld_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BcntW-1:0]     burst_q, burst_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic [15:0]          words_served_q, words_served_d;

  logic [IdxW-1:0]      pick_idx;
  logic                 pick_found;
  logic                 keep_owner;
  logic                 accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx),
    .found  (pick_found)
  );

  // The previous owner keeps the port while it still asks and has burst budget left.
  assign keep_owner = own_vld_q && req[owner_q] && (burst_q < BcntW'(BURST_MAX));
  // gnt_q is one-hot on the owner, so this ignores out_ready of everyone else.
  assign accept     = |(out_ready & gnt_q);

  // Next-state: IDLE decides the owner, FETCH pops and captures, HOLD waits for accept.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    owner_d        = owner_q;
    own_vld_d      = own_vld_q;
    rr_ptr_d       = rr_ptr_q;
    burst_d        = burst_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    words_served_d = words_served_q;
    case (state_q)
      StIdle: begin
        // rempty here already reflects the last pop, so a FETCH pop is always valid.
        if (!rempty && (|req)) begin
          state_d   = StFetch;
          own_vld_d = 1'b1;
          gnt_d     = '0;
          if (keep_owner) begin
            gnt_d[owner_q] = 1'b1;
          end else if (pick_found) begin
            owner_d         = pick_idx;
            rr_ptr_d        = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            burst_d         = '0;
            gnt_d[pick_idx] = 1'b1;
          end
        end else begin
          gnt_d = '0;
        end
      end
      StFetch: begin
        out_data_d  = rdata;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (accept) begin
          out_valid_d    = 1'b0;
          words_served_d = words_served_q + 16'd1;
          state_d        = StIdle;
          if (burst_q < BcntW'(BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q        <= StIdle;
      gnt_q          <= '0;
      owner_q        <= '0;
      own_vld_q      <= 1'b0;
      rr_ptr_q       <= '0;
      burst_q        <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      words_served_q <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      owner_q        <= owner_d;
      own_vld_q      <= own_vld_d;
      rr_ptr_q       <= rr_ptr_d;
      burst_q        <= burst_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      words_served_q <= words_served_d;
    end
  end

  assign rinc         = (state_q == StFetch);
  assign gnt          = gnt_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign words_served = words_served_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: a directed vector table plus sequences driven by a
// small FIFO model whose empty flag lags a pop by one cycle.
module tb_fifo_read_arbiter;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready = '0;
  logic [15:0] words_served;

  int n_vec = 0;
  int n_bad = 0;

  // Stimulus source select: direct vector values or the FIFO model.
  logic       use_model = 1'b0;
  logic       vec_rempty = 1'b1;
  logic [7:0] vec_rdata = '0;
  logic       mdl_rempty;
  logic [7:0] mdl_rdata;
  logic [7:0] mem [32];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         mdl_cnt;

  assign mdl_cnt = wr_ptr - rd_ptr;
  assign rempty  = use_model ? mdl_rempty : vec_rempty;
  assign rdata   = use_model ? mdl_rdata : vec_rdata;

  always #5 rclk = ~rclk;

  fifo_read_arbiter #(
    .DATA_SIZE (8),
    .NUM_REQ   (4),
    .BURST_MAX (2)
  ) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .rempty       (rempty),
    .rdata        (rdata),
    .rinc         (rinc),
    .req          (req),
    .gnt          (gnt),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .words_served (words_served)
  );

  // FIFO model: empty flag reflects the count before this edge's pop.
  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rd_ptr     <= wr_ptr;
      mdl_rempty <= 1'b1;
      mdl_rdata  <= '0;
    end else begin
      mdl_rempty <= (mdl_cnt == 0);
      if (use_model && rinc && mdl_cnt > 0) begin
        rd_ptr    <= rd_ptr + 1;
        mdl_rdata <= (mdl_cnt > 1) ? mem[(rd_ptr + 1) % 32] : 8'h00;
      end else begin
        mdl_rdata <= (mdl_cnt > 0) ? mem[rd_ptr % 32] : 8'h00;
      end
    end
  end

  typedef struct packed {
    logic       e;
    logic [7:0] d;
    logic [3:0] r;
    logic [3:0] rdy;
    logic [3:0] g;
    logic       inc;
    logic       v;
    logic [7:0] od;
    logic [15:0] ws;
  } vec_t;

  vec_t tv [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % 32] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input string name);
    bit got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(posedge rclk);
      #1;
      got = out_valid;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge rclk);
    rrst = 1'b1;
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  initial begin
    int exp_own [8];
    int nseen;
    int pulses;
    int adj;
    logic prev;
    bit seen;

    // e, rdata, req, ready | gnt, rinc, valid, out_data, words_served
    tv[0]  = '{1'b1, 8'h00, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 16'd0};
    tv[1]  = '{1'b0, 8'hA5, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 8'h00, 16'd0};
    tv[2]  = '{1'b0, 8'hA5, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 8'hA5, 16'd0};
    tv[3]  = '{1'b0, 8'h3C, 4'b0001, 4'b1110, 4'b0001, 1'b0, 1'b1, 8'hA5, 16'd0};
    tv[4]  = '{1'b0, 8'h3C, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'hA5, 16'd1};
    tv[5]  = '{1'b0, 8'h3C, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 8'hA5, 16'd1};
    tv[6]  = '{1'b0, 8'h3C, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 8'h3C, 16'd1};
    tv[7]  = '{1'b0, 8'h3C, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'h3C, 16'd2};
    tv[8]  = '{1'b1, 8'h3C, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h3C, 16'd2};
    tv[9]  = '{1'b0, 8'h77, 4'b0110, 4'b0000, 4'b0100, 1'b1, 1'b0, 8'h3C, 16'd2};
    tv[10] = '{1'b0, 8'h77, 4'b0110, 4'b0000, 4'b0100, 1'b0, 1'b1, 8'h77, 16'd2};
    tv[11] = '{1'b0, 8'h77, 4'b0110, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'h77, 16'd3};
    tv[12] = '{1'b0, 8'h11, 4'b0110, 4'b0000, 4'b0010, 1'b1, 1'b0, 8'h77, 16'd3};
    tv[13] = '{1'b0, 8'h11, 4'b0110, 4'b0000, 4'b0010, 1'b0, 1'b1, 8'h11, 16'd3};
    tv[14] = '{1'b0, 8'h11, 4'b0110, 4'b1111, 4'b0010, 1'b0, 1'b0, 8'h11, 16'd4};
    tv[15] = '{1'b0, 8'h99, 4'b1001, 4'b0000, 4'b1000, 1'b1, 1'b0, 8'h11, 16'd4};
    tv[16] = '{1'b0, 8'h99, 4'b1001, 4'b0000, 4'b1000, 1'b0, 1'b1, 8'h99, 16'd4};
    tv[17] = '{1'b0, 8'h99, 4'b1001, 4'b1000, 4'b1000, 1'b0, 1'b0, 8'h99, 16'd5};
    tv[18] = '{1'b0, 8'h42, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 8'h99, 16'd5};
    tv[19] = '{1'b0, 8'h42, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 8'h42, 16'd5};
    tv[20] = '{1'b0, 8'h42, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'h42, 16'd6};
    tv[21] = '{1'b1, 8'h42, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h42, 16'd6};
    exp_own = '{0, 0, 1, 1, 2, 2, 3, 3};

    // Reset values while rrst is held.
    repeat (2) @(posedge rclk);
    #1;
    chk("reset_state", {gnt, rinc, out_valid, out_data, words_served},
        {4'b0000, 1'b0, 1'b0, 8'h00, 16'd0});
    @(negedge rclk);
    rrst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 22; i++) begin
      @(negedge rclk);
      vec_rempty = tv[i].e;
      vec_rdata  = tv[i].d;
      req        = tv[i].r;
      out_ready  = tv[i].rdy;
      @(posedge rclk);
      #1;
      chk($sformatf("vec%0d", i), {gnt, rinc, out_valid, out_data, words_served},
          {tv[i].g, tv[i].inc, tv[i].v, tv[i].od, tv[i].ws});
    end

    // Empty FIFO with a pending request, then one word arrives.
    @(negedge rclk);
    use_model = 1'b1;
    req       = 4'b0001;
    out_ready = 4'b0000;
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge rclk);
      #1;
      chk("empty_idle", {gnt, rinc}, {4'b0000, 1'b0});
    end
    @(negedge rclk);
    push(8'hA5);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(posedge rclk);
      #1;
      seen = rinc;
    end
    chk("first_pop", {gnt, 1'(seen)}, {4'b0001, 1'b1});
    @(posedge rclk);
    #1;
    chk("first_word", {rinc, out_valid, out_data}, {1'b0, 1'b1, 8'hA5});
    @(negedge rclk);
    out_ready = 4'b0001;
    @(posedge rclk);
    #1;
    chk("first_accept", {out_valid, words_served}, {1'b0, 16'd1});

    // Burst limit of 2 across four requesters, eight preloaded words.
    @(negedge rclk);
    req = 4'b0000;
    pulse_reset();
    for (int k = 0; k < 8; k++) push(8'h10 + 8'(k));
    out_ready = 4'b1111;
    repeat (2) @(negedge rclk);
    req   = 4'b1111;
    nseen = 0;
    for (int c = 0; c < 80 && nseen < 8; c++) begin
      @(posedge rclk);
      #1;
      if (out_valid) begin
        chk($sformatf("burst_owner%0d", nseen), 32'(oh2idx(gnt)), 32'(exp_own[nseen]));
        chk($sformatf("burst_data%0d", nseen), 32'(out_data), 32'(8'h10 + 8'(nseen)));
        nseen++;
      end
    end
    chk("burst_words_seen", 32'(nseen), 32'd8);
    @(posedge rclk);
    #1;
    chk("burst_served", 32'(words_served), 32'd8);

    // Single word with the request held: one pop, then idle with no grant.
    @(negedge rclk);
    req = 4'b0001;
    push(8'hAB);
    pulses = 0;
    adj    = 0;
    prev   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge rclk);
      #1;
      if (rinc) pulses++;
      if (rinc && prev) adj++;
      prev = rinc;
    end
    chk("single_pops", 32'(pulses), 32'd1);
    chk("adjacent_pops", 32'(adj), 32'd0);
    chk("single_idle", {gnt, out_valid, words_served}, {4'b0000, 1'b0, 16'd9});

    // Owner stalls for five cycles in HOLD.
    @(negedge rclk);
    req       = 4'b0010;
    out_ready = 4'b0000;
    push(8'h5A);
    wait_valid("stall_valid");
    chk("stall_first", {gnt, out_data}, {4'b0010, 8'h5A});
    for (int c = 0; c < 5; c++) begin
      @(posedge rclk);
      #1;
      chk($sformatf("stall%0d", c), {out_valid, out_data, gnt, rinc},
          {1'b1, 8'h5A, 4'b0010, 1'b0});
    end
    @(negedge rclk);
    out_ready = 4'b0010;
    @(posedge rclk);
    #1;
    chk("stall_accept", {out_valid, words_served}, {1'b0, 16'd10});

    // Asynchronous reset in the middle of HOLD.
    @(negedge rclk);
    req       = 4'b0001;
    out_ready = 4'b0000;
    push(8'h66);
    wait_valid("rst_valid");
    #3;
    rrst = 1'b1;
    #1;
    chk("async_reset", {out_valid, gnt, rinc, out_data, words_served},
        {1'b0, 4'b0000, 1'b0, 8'h00, 16'd0});
    @(negedge rclk);
    rrst   = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge rclk);
      #1;
      if (rinc) pulses++;
    end
    chk("post_reset_no_pop", 32'(pulses), 32'd0);
    @(negedge rclk);
    push(8'h21);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(posedge rclk);
      #1;
      seen = rinc;
    end
    chk("post_reset_pop", {gnt, 1'(seen)}, {4'b0001, 1'b1});
    @(posedge rclk);
    #1;
    chk("post_reset_word", {out_valid, out_data}, {1'b1, 8'h21});
    @(negedge rclk);
    out_ready = 4'b0001;
    @(posedge rclk);
    #1;
    chk("post_reset_accept", 32'(words_served), 32'd1);

    // Served-word counter wraps from 16'hFFFF to zero.
    @(negedge rclk);
    out_ready = 4'b0000;
    force dut.words_served_q = 16'hFFFF;
    @(posedge rclk);
    @(negedge rclk);
    release dut.words_served_q;
    out_ready = 4'b0001;
    push(8'h0F);
    wait_valid("wrap_valid");
    @(posedge rclk);
    #1;
    chk("wrap", 32'(words_served), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
